// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M multiply/divide unit in the execute stage.
// FSM IDLE -> CALC -> DONE. The unit multiplies by radix-2 shift-add and divides by restoring
// division, both on operand magnitudes. The sign fix-up is applied in DONE.
// Divide-by-zero, signed overflow and (optionally) all MUL ops skip CALC and take the short path.
// Config macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU use a
// single-cycle multiplier and take the short path. Divides always iterate.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   hi_q, lo_q, opa_q;
  logic              neg_q_q, neg_r_q;
  logic [XLEN-1:0]   result_hold_q;

  // ---------------- start-time operand decode ----------------
  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast_mul, short_path;

  assign is_div   = funct3_i[2];
  assign a_signed = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                    (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign b_signed = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
  assign a_neg    = a_signed & rs1_i[XLEN-1];
  assign b_neg    = b_signed & rs2_i[XLEN-1];
  assign a_mag    = a_neg ? -rs1_i : rs1_i;
  assign b_mag    = b_neg ? -rs2_i : rs2_i;
  assign div_zero = is_div & (rs2_i == '0);
  assign div_ovf  = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                    (rs2_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_mul  = ~is_div;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
  assign fast_mul  = 1'b0;
`endif

  assign short_path = div_zero | div_ovf | fast_mul;

  // ---------------- one radix-2 iteration ----------------
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [XLEN-1:0] hi_step, lo_step;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
  assign rem_sh   = {hi_q, lo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opa_q};

  // Select the multiply (shift-add) or divide (restoring) step for the latched op.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hi_step = hi_q;
    lo_step = lo_q;
    if (funct3_q[2]) begin
      if (!rem_diff[XLEN]) begin
        hi_step = rem_diff[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_step = rem_sh[XLEN-1:0];
        lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // ---------------- sign fix-up from registered magnitudes ----------------
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   result_fix;

  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q_q ? -prod : prod;

  // Pick the result field for the latched funct3 and apply the sign.
  always_comb begin
    result_fix = '0;
    unique case (funct3_q)
      3'b000:                 result_fix = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_fix = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_fix = neg_q_q ? -lo_q : lo_q;
      default:                result_fix = neg_r_q ? -hi_q : hi_q;
    endcase
  end

  // ---------------- FSM ----------------
  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus stall/valid strobes. kill_i overrides everything.
  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        stall_o = 1'b1;
        state_d = short_path ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall_o = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        result_valid_o = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) begin
      state_d        = S_IDLE;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
    end
  end

  // Datapath: latch operands at start, iterate in CALC, keep the delivered result.
  // NOTE: datapath registers are reset too, so result_o and rd_o read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      opa_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      result_hold_q <= '0;
    end else if (kill_i) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          funct3_q <= funct3_i;
          rd_q     <= rd_i;
          cnt_q    <= '0;
          if (div_zero) begin
            hi_q    <= rs1_i;
            lo_q    <= '1;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end else if (div_ovf) begin
            hi_q    <= '0;
            lo_q    <= {1'b1, {(XLEN-1){1'b0}}};
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (fast_mul) begin
            {hi_q, lo_q} <= fast_prod;
            neg_q_q      <= a_neg ^ b_neg;
            neg_r_q      <= 1'b0;
          end
`endif
          else begin
            cnt_q   <= CNT_W'(XLEN-1);
            hi_q    <= '0;
            lo_q    <= is_div ? a_mag : b_mag;
            opa_q   <= is_div ? b_mag : a_mag;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
          end
        end
        S_CALC: begin
          hi_q <= hi_step;
          lo_q <= lo_step;
          if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        end
        S_DONE: result_hold_q <= result_fix;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign result_o = (state_q == S_DONE) ? result_fix : result_hold_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed bench for ex_muldiv_unit.
// Expected values come from an arithmetic model of RV32M. Selected ops also carry
// hand-computed literal results and latencies. One negedge process does all comparisons.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;
  localparam int NONE = 32'h7fff_ffff;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic            kill_i = 1'b0;
  logic [2:0]      funct3_i = '0;
  logic [XLEN-1:0] rs1_i = '0;
  logic [XLEN-1:0] rs2_i = '0;
  logic [4:0]      rd_i = '0;
  logic            stall_o, busy_o, result_valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .kill_i(kill_i),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .stall_o(stall_o), .busy_o(busy_o), .result_valid_o(result_valid_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          issue;
    int          due;
    int          kill_cyc;
    logic [31:0] res;
    logic [4:0]  rd;
    int          lit_due;
    logic [31:0] lit_res;
  } op_t;
  op_t ops[$];

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Cycles from accepted start to result strobe.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return MUL_LAT;
  endfunction

  // Single compare process: every cycle, outputs against the model's schedule.
  logic [31:0] last_res = '0;
  always @(negedge clk) begin
    logic e_stall, e_busy, e_valid;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    if (!rst_n) begin
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(result_valid_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      check("rst_rd", 32'(rd_o), 32'd0);
      last_res = '0;
    end else begin
      e_stall = 1'b0; e_busy = 1'b0; e_valid = 1'b0; e_res = '0; e_rd = '0;
      foreach (ops[i]) begin
        if (ops[i].issue <= cyc && cyc < ops[i].due && cyc < ops[i].kill_cyc) e_stall = 1'b1;
        if (ops[i].issue < cyc && cyc <= ops[i].due && cyc <= ops[i].kill_cyc) e_busy = 1'b1;
        if (cyc == ops[i].due && cyc < ops[i].kill_cyc) begin
          e_valid = 1'b1; e_res = ops[i].res; e_rd = ops[i].rd;
        end
        if (cyc == ops[i].lit_due) begin
          check({ops[i].tag, "_lit_valid"}, 32'(result_valid_o), 32'd1);
          check({ops[i].tag, "_lit_result"}, result_o, ops[i].lit_res);
        end
      end
      check("stall", 32'(stall_o), 32'(e_stall));
      check("busy", 32'(busy_o), 32'(e_busy));
      check("valid", 32'(result_valid_o), 32'(e_valid));
      if (e_valid) begin
        check("result", result_o, e_res);
        check("rd", 32'(rd_o), 32'(e_rd));
        last_res = e_res;
      end else begin
        check("result_hold", result_o, last_res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op starting this cycle; runs until the cycle after its result slot.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input bit hold,
                       input int kill_at, input bit use_rst,
                       input logic [31:0] lit_res, input int lit_lat);
    op_t e;
    int lat;
    lat = model_lat(f3, a, b);
    start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
    e.tag      = tag;
    e.issue    = cyc;
    e.due      = cyc + lat;
    e.kill_cyc = (kill_at >= 0) ? cyc + kill_at : NONE;
    e.res      = model(f3, a, b);
    e.rd       = rd;
    e.lit_due  = (lit_lat >= 0) ? cyc + lit_lat : -1;
    e.lit_res  = lit_res;
    ops.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0 && !hold) start_i = 1'b0;
      if (k > 0 && use_rst && k == kill_at + 1) rst_n = 1'b1;
      kill_i = 1'b0;
      if (k == kill_at) begin
        if (use_rst) rst_n = 1'b0;
        else         kill_i = 1'b1;
      end
      step();
    end
    start_i = 1'b0;
    kill_i  = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step();

    // Divides on the iterative path, with hand-computed results and latency.
    issue("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1, 0, -1, 0, 32'hFFFF_FFFD, 33);
    issue("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2, 0, -1, 0, 32'hFFFF_FFFF, 33);

    // Special cases take the short path.
    issue("divu_by0", 3'b101, 32'h10, 32'd0, 5'd3, 0, -1, 0, 32'hFFFF_FFFF, 1);
    issue("rem_by0", 3'b110, 32'd5, 32'd0, 5'd4, 0, -1, 0, 32'd5, 1);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, -1, 0, 32'h8000_0000, 1);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, -1, 0, 32'd0, 1);

    // High-half multiplies.
    issue("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, -1, 0, 32'h0, MUL_LAT);
    issue("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0, -1, 0, 32'hFFFF_FFFE, MUL_LAT);
    issue("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd9, 0, -1, 0, 32'hFFFF_FFFF, MUL_LAT);
    issue("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 0, -1, 0, 32'h4000_0000, MUL_LAT);

    // Model-only vectors across signedness combinations.
    issue("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd5, 5'd11, 0, -1, 0, '0, -1);
    issue("mulhsu_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, -1, 0, '0, -1);
    issue("mulhu_big", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, 0, -1, 0, '0, -1);
    issue("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd14, 0, -1, 0, '0, -1);
    issue("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 5'd15, 0, -1, 0, '0, -1);
    issue("divu_max3", 3'b101, 32'hFFFF_FFFF, 32'd3, 5'd16, 0, -1, 0, '0, -1);
    issue("remu_big", 3'b111, 32'hDEAD_BEEF, 32'h0001_0001, 5'd17, 0, -1, 0, '0, -1);
    issue("div_min_1", 3'b100, 32'h8000_0000, 32'd1, 5'd18, 0, -1, 0, '0, -1);
    issue("remu_by0", 3'b111, 32'd7, 32'd0, 5'd19, 0, -1, 0, '0, -1);

    // Kill during the 10th CALC cycle: no result, stall drops at once.
    issue("div_kill", 3'b100, 32'd1000, 32'd3, 5'd20, 0, 10, 0, '0, -1);
    // Kill together with start in IDLE: the op is never accepted.
    issue("kill_start", 3'b101, 32'd9, 32'd2, 5'd21, 0, 0, 0, '0, -1);
    // start_i held through DONE: exactly one result.
    issue("hold_start", 3'b101, 32'd50, 32'd5, 5'd22, 1, -1, 0, 32'd10, 33);

    // Back-to-back: the second start falls in the cycle right after DONE.
    issue("b2b_mul", 3'b000, 32'd3, 32'd4, 5'd23, 0, -1, 0, 32'd12, MUL_LAT);
    issue("b2b_divu", 3'b101, 32'd100, 32'd7, 5'd24, 0, -1, 0, 32'd14, 33);

    // Reset pulse mid-divide: no result, all outputs back to zero.
    issue("div_rst", 3'b100, 32'd77, 32'd5, 5'd25, 0, 15, 1, '0, -1);
    issue("after_rst", 3'b111, 32'd77, 32'd5, 5'd26, 0, -1, 0, 32'd2, 33);

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
